// File: rtl/clock_set_pkg.sv
// Shared types, field codes and limits for the clock time-set controller.
package clock_set_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    SET_SEC  = 3'd3,
    COMMIT   = 3'd4
  } state_e;

  typedef logic [5:0] time_field_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam time_field_t SEC_MAX = 6'd59;
  localparam time_field_t MIN_MAX = 6'd59;

  function automatic logic [1:0] field_of(state_e st);
    logic [1:0] f;
    case (st)
      SET_HOUR: f = FIELD_HOUR;
      SET_MIN:  f = FIELD_MIN;
      SET_SEC:  f = FIELD_SEC;
      default:  f = FIELD_NONE;
    endcase
    return f;
  endfunction

  function automatic time_field_t clamp_field(time_field_t v, time_field_t max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/clock_set_field.sv
// Modular up/down time-field register with clamped parallel load.
module clock_set_field
  import clock_set_pkg::*;
#(
  parameter time_field_t MAX = SEC_MAX
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [5:0] load_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [5:0] val_o
);

  time_field_t val_q, val_d;

  // inc and dec together cancel out; the register never leaves 0..MAX
  always_comb begin
    if (load_i) begin
      val_d = clamp_field(load_val_i, MAX);
    end else if (inc_i && !dec_i) begin
      val_d = (val_q >= MAX) ? 6'd0 : val_q + 6'd1;
    end else if (dec_i && !inc_i) begin
      val_d = (val_q == 6'd0) ? MAX : val_q - 6'd1;
    end else begin
      val_d = val_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      val_q <= 6'd0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time-set controller: capture live time, edit h/m/s, strobe a load.
// Optional hold-to-repeat buttons are enabled with CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int unsigned HOUR_MAX   = 23,
  parameter int unsigned TIMEOUT_MS = 10000,
  parameter int unsigned TO_W       = 14
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  , parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
`endif
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_ms_i,
  input  logic       mode_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       cancel_i,
  input  logic [5:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  output logic [5:0] hour_set_o,
  output logic [5:0] min_set_o,
  output logic [5:0] sec_set_o,
  output logic       load_o,
  output logic       editing_o,
  output logic [1:0] field_o
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  , input  logic     inc_hold_i,
  input  logic       dec_hold_i
`endif
);

  localparam time_field_t HOUR_MAX_F = time_field_t'(HOUR_MAX);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_MS);
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            load_q, load_d, editing_q, editing_d;
  logic [1:0]      field_q, field_d;
  logic            in_set_s, activity_s, abort_s, capture_s, step_ok_s;
  logic            inc_s, dec_s, rep_inc_s, rep_dec_s;
  logic            hour_inc_s, hour_dec_s, min_inc_s, min_dec_s, sec_inc_s, sec_dec_s;

  assign in_set_s = (state_q == SET_HOUR) || (state_q == SET_MIN) || (state_q == SET_SEC);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        rep_run_q, rep_run_d, rep_fire_s, one_hold_s;

  // First repeat after the hold delay, then one every repeat period until release
  always_comb begin
    one_hold_s = in_set_s && (inc_hold_i ^ dec_hold_i);
    rep_cnt_d  = rep_cnt_q;
    rep_run_d  = rep_run_q;
    rep_fire_s = 1'b0;
    if (!one_hold_s) begin
      rep_cnt_d = 16'd0;
      rep_run_d = 1'b0;
    end else if (tick_ms_i) begin
      if ((rep_cnt_q + 16'd1) >= (rep_run_q ? 16'(REPEAT_RATE_MS) : 16'(REPEAT_DELAY_MS))) begin
        rep_cnt_d  = 16'd0;
        rep_run_d  = 1'b1;
        rep_fire_s = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 16'd1;
      end
    end else begin
      rep_cnt_d = rep_cnt_q;
    end
    rep_inc_s = rep_fire_s && inc_hold_i;
    rep_dec_s = rep_fire_s && dec_hold_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rep_cnt_q <= 16'd0;
      rep_run_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_run_q <= rep_run_d;
    end
  end
`else
  assign rep_inc_s = 1'b0;
  assign rep_dec_s = 1'b0;
`endif

  // Priority: cancel/timeout over mode over inc/dec
  always_comb begin
    activity_s = mode_i || inc_i || dec_i || cancel_i || rep_inc_s || rep_dec_s;
    abort_s    = in_set_s && (cancel_i || (to_cnt_q == TO_LIMIT));
    capture_s  = (state_q == RUN) && mode_i;
    step_ok_s  = in_set_s && !abort_s && !mode_i;
    inc_s      = step_ok_s && (inc_i || rep_inc_s);
    dec_s      = step_ok_s && (dec_i || rep_dec_s);
    hour_inc_s = inc_s && (state_q == SET_HOUR);
    hour_dec_s = dec_s && (state_q == SET_HOUR);
    min_inc_s  = inc_s && (state_q == SET_MIN);
    min_dec_s  = dec_s && (state_q == SET_MIN);
    sec_inc_s  = inc_s && (state_q == SET_SEC);
    sec_dec_s  = dec_s && (state_q == SET_SEC);

    state_d = state_q;
    case (state_q)
      RUN:      state_d = mode_i ? SET_HOUR : RUN;
      SET_HOUR: state_d = abort_s ? RUN : (mode_i ? SET_MIN : SET_HOUR);
      SET_MIN:  state_d = abort_s ? RUN : (mode_i ? SET_SEC : SET_MIN);
      SET_SEC:  state_d = abort_s ? RUN : (mode_i ? COMMIT : SET_SEC);
      COMMIT:   state_d = RUN;
      default:  state_d = RUN;
    endcase

    // Counter rests at 0 outside editing, so entering SET_HOUR starts it cleared
    if (!in_set_s || activity_s || abort_s) begin
      to_cnt_d = {TO_W{1'b0}};
    end else if (tick_ms_i && (to_cnt_q != TO_LIMIT)) begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    load_d    = (state_d == COMMIT);
    editing_d = (state_d == SET_HOUR) || (state_d == SET_MIN) || (state_d == SET_SEC);
    field_d   = field_of(state_d);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= RUN;
      to_cnt_q  <= {TO_W{1'b0}};
      load_q    <= 1'b0;
      editing_q <= 1'b0;
      field_q   <= FIELD_NONE;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      load_q    <= load_d;
      editing_q <= editing_d;
      field_q   <= field_d;
    end
  end

  clock_set_field #(.MAX(HOUR_MAX_F)) u_hour (
    .clk_i(clk_i), .reset_i(reset_i), .load_i(capture_s), .load_val_i(hour_i),
    .inc_i(hour_inc_s), .dec_i(hour_dec_s), .val_o(hour_set_o)
  );

  clock_set_field #(.MAX(MIN_MAX)) u_min (
    .clk_i(clk_i), .reset_i(reset_i), .load_i(capture_s), .load_val_i(min_i),
    .inc_i(min_inc_s), .dec_i(min_dec_s), .val_o(min_set_o)
  );

  clock_set_field #(.MAX(SEC_MAX)) u_sec (
    .clk_i(clk_i), .reset_i(reset_i), .load_i(capture_s), .load_val_i(sec_i),
    .inc_i(sec_inc_s), .dec_i(sec_dec_s), .val_o(sec_set_o)
  );

  assign load_o    = load_q;
  assign editing_o = editing_q;
  assign field_o   = field_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: vector table plus timeout and reset sequences.
module tb_clock_set_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tick, mode, inc, dec, cancel;
  logic [5:0] hour_in, min_in, sec_in, hour_set, min_set, sec_set;
  logic       load, editing;
  logic [1:0] field;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  logic       inc_hold = 1'b0, dec_hold = 1'b0;
`endif

  clock_set_ctrl dut (
    .clk_i(clk), .reset_i(reset), .tick_ms_i(tick), .mode_i(mode), .inc_i(inc),
    .dec_i(dec), .cancel_i(cancel), .hour_i(hour_in), .min_i(min_in), .sec_i(sec_in),
    .hour_set_o(hour_set), .min_set_o(min_set), .sec_set_o(sec_set),
    .load_o(load), .editing_o(editing), .field_o(field)
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    , .inc_hold_i(inc_hold), .dec_hold_i(dec_hold)
`endif
  );

  // btn bits: [3]=mode [2]=inc [1]=dec [0]=cancel
  typedef struct {
    logic [3:0] btn;
    int h, m, s;
    int eh, em, es;
    logic el, ee;
    int ef;
  } vec_t;

  localparam logic [3:0] N = 4'b0000, M = 4'b1000, I = 4'b0100, D = 4'b0010, C = 4'b0001;

  vec_t vecs[$];
  vec_t exp_q[$];
  int n_vec = 0, n_bad = 0, load_seen = 0, ls = 0;

  always @(negedge clk) if (load === 1'b1) load_seen++;

  function automatic vec_t V(logic [3:0] b, int h, int m, int s, int eh, int em, int es,
                             logic el, logic ee, int ef);
    vec_t r;
    r.btn = b; r.h = h; r.m = m; r.s = s;
    r.eh = eh; r.em = em; r.es = es; r.el = el; r.ee = ee; r.ef = ef;
    return r;
  endfunction

  task automatic chk(string nm, int idx, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic press(logic [3:0] b);
    {mode, inc, dec, cancel} = b;
    @(posedge clk); #1;
    {mode, inc, dec, cancel} = 4'b0000;
  endtask

  task automatic cyc(logic t);
    tick = t;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  initial begin
    vec_t e;
    reset = 1'b1; tick = 1'b0; {mode, inc, dec, cancel} = 4'b0000;
    hour_in = 6'd0; min_in = 6'd0; sec_in = 6'd0;

    // 13:45:30 -> 16:45:30 commit
    vecs.push_back(V(N, 13,45,30,  0, 0, 0, 1'b0,1'b0,0));
    vecs.push_back(V(M, 13,45,30, 13,45,30, 1'b0,1'b1,1));
    vecs.push_back(V(I, 13,45,30, 14,45,30, 1'b0,1'b1,1));
    vecs.push_back(V(I, 13,45,30, 15,45,30, 1'b0,1'b1,1));
    vecs.push_back(V(I, 13,45,30, 16,45,30, 1'b0,1'b1,1));
    vecs.push_back(V(M, 13,45,30, 16,45,30, 1'b0,1'b1,2));
    vecs.push_back(V(M, 13,45,30, 16,45,30, 1'b0,1'b1,3));
    vecs.push_back(V(M, 13,45,30, 16,45,30, 1'b1,1'b0,0));
    vecs.push_back(V(N, 13,45,30, 16,45,30, 1'b0,1'b0,0));
    // 23:59:59 -> all fields wrap up to 00:00:00
    vecs.push_back(V(M, 23,59,59, 23,59,59, 1'b0,1'b1,1));
    vecs.push_back(V(I, 23,59,59,  0,59,59, 1'b0,1'b1,1));
    vecs.push_back(V(M, 23,59,59,  0,59,59, 1'b0,1'b1,2));
    vecs.push_back(V(I, 23,59,59,  0, 0,59, 1'b0,1'b1,2));
    vecs.push_back(V(M, 23,59,59,  0, 0,59, 1'b0,1'b1,3));
    vecs.push_back(V(I, 23,59,59,  0, 0, 0, 1'b0,1'b1,3));
    vecs.push_back(V(M, 23,59,59,  0, 0, 0, 1'b1,1'b0,0));
    vecs.push_back(V(N, 23,59,59,  0, 0, 0, 1'b0,1'b0,0));
    // 00:00:00 -> wrap down, then cancel keeps values; RUN ignores inc/cancel
    vecs.push_back(V(M,  0, 0, 0,  0, 0, 0, 1'b0,1'b1,1));
    vecs.push_back(V(D,  0, 0, 0, 23, 0, 0, 1'b0,1'b1,1));
    vecs.push_back(V(M,  0, 0, 0, 23, 0, 0, 1'b0,1'b1,2));
    vecs.push_back(V(D,  0, 0, 0, 23,59, 0, 1'b0,1'b1,2));
    vecs.push_back(V(C,  0, 0, 0, 23,59, 0, 1'b0,1'b0,0));
    vecs.push_back(V(I,  0, 0, 0, 23,59, 0, 1'b0,1'b0,0));
    vecs.push_back(V(C,  0, 0, 0, 23,59, 0, 1'b0,1'b0,0));
    // out-of-range live time is clamped on capture
    vecs.push_back(V(M, 30,61,63, 23,59,59, 1'b0,1'b1,1));
    vecs.push_back(V(I, 30,61,63,  0,59,59, 1'b0,1'b1,1));
    vecs.push_back(V(C, 30,61,63,  0,59,59, 1'b0,1'b0,0));
    // priority: mode+cancel, inc+dec, mode+inc in SET_SEC
    vecs.push_back(V(M,     10,20,30, 10,20,30, 1'b0,1'b1,1));
    vecs.push_back(V(M,     10,20,30, 10,20,30, 1'b0,1'b1,2));
    vecs.push_back(V(M,     10,20,30, 10,20,30, 1'b0,1'b1,3));
    vecs.push_back(V(M | C, 10,20,30, 10,20,30, 1'b0,1'b0,0));
    vecs.push_back(V(M,     10,20,30, 10,20,30, 1'b0,1'b1,1));
    vecs.push_back(V(M,     10,20,30, 10,20,30, 1'b0,1'b1,2));
    vecs.push_back(V(M,     10,20,30, 10,20,30, 1'b0,1'b1,3));
    vecs.push_back(V(I | D, 10,20,30, 10,20,30, 1'b0,1'b1,3));
    vecs.push_back(V(I,     10,20,30, 10,20,31, 1'b0,1'b1,3));
    vecs.push_back(V(D,     10,20,30, 10,20,30, 1'b0,1'b1,3));
    vecs.push_back(V(M | I, 10,20,30, 10,20,30, 1'b1,1'b0,0));
    vecs.push_back(V(N,     10,20,30, 10,20,30, 1'b0,1'b0,0));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      {mode, inc, dec, cancel} = vecs[i].btn;
      hour_in = 6'(vecs[i].h); min_in = 6'(vecs[i].m); sec_in = 6'(vecs[i].s);
      exp_q.push_back(vecs[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("hour", i, int'(hour_set), e.eh);
      chk("min", i, int'(min_set), e.em);
      chk("sec", i, int'(sec_set), e.es);
      chk("load", i, int'(load), int'(e.el));
      chk("editing", i, int'(editing), int'(e.ee));
      chk("field", i, int'(field), e.ef);
    end
    {mode, inc, dec, cancel} = 4'b0000;

    // timeout in SET_MIN abandons the edit without a load
    hour_in = 6'd1; min_in = 6'd2; sec_in = 6'd3;
    press(M); press(M);
    ls = load_seen;
    repeat (9999) cyc(1'b1);
    chk("to_pre_editing", 0, int'(editing), 1);
    chk("to_pre_field", 0, int'(field), 2);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    chk("to_editing", 0, int'(editing), 0);
    chk("to_field", 0, int'(field), 0);
    chk("to_min_kept", 0, int'(min_set), 2);
    chk("to_no_load", 0, load_seen, ls);

    // a button press restarts the timeout count
    press(M); press(M);
    repeat (9999) cyc(1'b1);
    press(I);
    repeat (9999) cyc(1'b1);
    chk("to_restart_editing", 1, int'(editing), 1);
    chk("to_restart_min", 1, int'(min_set), 3);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    chk("to_restart_expire", 1, int'(editing), 0);
    chk("to_restart_no_load", 1, load_seen, ls);

    // asynchronous reset mid SET_HOUR
    hour_in = 6'd5; min_in = 6'd6; sec_in = 6'd7;
    press(M); press(I);
    chk("pre_rst_hour", 0, int'(hour_set), 6);
    #3 reset = 1'b1;
    #1;
    chk("rst_hour", 0, int'(hour_set), 0);
    chk("rst_min", 0, int'(min_set), 0);
    chk("rst_sec", 0, int'(sec_set), 0);
    chk("rst_load", 0, int'(load), 0);
    chk("rst_editing", 0, int'(editing), 0);
    chk("rst_field", 0, int'(field), 0);
    @(posedge clk); #1 reset = 1'b0;
    press(I);
    chk("post_rst_run_editing", 0, int'(editing), 0);
    chk("post_rst_run_hour", 0, int'(hour_set), 0);
    chk("post_rst_no_load", 0, load_seen, ls);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Button-driven time-set controller for the 24-hour millisecond clock datapath.
- Captures the running time, then lets the user edit hour, minute and second in sequence.
- Issues a one-cycle load of the edited values into the clock counters.
- Sits between the debounced button front-end and the clock core; drives the clock's preset fields plus a load strobe.

Parameters:
- HOUR_MAX, 23: highest settable hour; wraps to 0.
- TIMEOUT_MS, 10000: ms ticks without button activity before an edit is abandoned.
- TO_W, 14: width of the timeout counter; must hold TIMEOUT_MS.
- REPEAT_DELAY_MS, 500: hold time before auto-repeat starts (macro only).
- REPEAT_RATE_MS, 100: auto-repeat period (macro only).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- tick_ms_i  in  1  single-cycle 1 ms strobe.
- mode_i  in  1  single-cycle pulse: enter edit / advance field.
- inc_i  in  1  single-cycle pulse: increment current field.
- dec_i  in  1  single-cycle pulse: decrement current field.
- cancel_i  in  1  single-cycle pulse: abandon edit.
- hour_i  in  6  live clock hour.
- min_i  in  6  live clock minute.
- sec_i  in  6  live clock second.
- hour_set_o  out  6  edited hour.
- min_set_o  out  6  edited minute.
- sec_set_o  out  6  edited second.
- load_o  out  1  one-cycle strobe; clock core loads *_set_o, clears ms.
- editing_o  out  1  high in any SET_* state.
- field_o  out  2  0=none, 1=hour, 2=min, 3=sec; for display blink.

Behaviour:
- Reset (async, active-high) values: state RUN; all *_set_o 0; load_o 0; editing_o 0; field_o 0; timeout counter 0.
- State RUN:
  - mode_i -> SET_HOUR, capturing hour_i/min_i/sec_i into the edit registers on the same edge.
  - inc_i, dec_i, cancel_i ignored.
- State SET_HOUR: mode_i -> SET_MIN. State SET_MIN: mode_i -> SET_SEC. State SET_SEC: mode_i -> COMMIT.
- State COMMIT: load_o=1 for exactly this cycle; next state RUN. Latency from the final mode_i edge to load_o is 1 cycle.
- Field arithmetic in SET_* states:
  - inc_i adds 1, dec_i subtracts 1, modular.
  - Hour wraps HOUR_MAX<->0; min and sec wrap 59<->0.
  - Registers never hold out-of-range values; a captured out-of-range input is clamped to its max.
- Priority within one cycle: cancel_i > mode_i > inc_i/dec_i.
  - inc_i with dec_i together: no change, but counts as activity.
  - mode_i with inc_i: advance only; the increment is dropped.
- cancel_i in SET_*: -> RUN; no load_o; *_set_o keep last edited values.
- Timeout:
  - Counter clears on any button pulse and on entry to SET_HOUR; advances on tick_ms_i while in SET_*.
  - At TIMEOUT_MS it behaves as cancel_i.
  - Counter saturates and is held at 0 in RUN.
- editing_o and field_o are registered and decoded from state; both are 0 in RUN and COMMIT.
- Reset mid-edit: immediate return to RUN, no load_o.

Optional Feature:
- Macro: CLOCK_SET_AUTO_REPEAT_EN. Adds inputs inc_hold_i and dec_hold_i (level, debounced).
- Defined:
  - A hold level on for REPEAT_DELAY_MS ticks generates an internal inc/dec every REPEAT_RATE_MS ticks until released.
  - Repeats count as activity.
  - Both holds active: no repeat.
- Undefined: the ports are absent; fields change only on pulses.

Decomposition:
- Package clock_set_pkg holds:
  - state enum RUN/SET_HOUR/SET_MIN/SET_SEC/COMMIT;
  - field codes;
  - constants SEC_MAX=59 and MIN_MAX=59;
  - the 6-bit time field type.
- One natural sub-module, clock_set_field: a modular up/down register with load, clamp and parameterised max.
  - Instantiated three times (hour, min, sec).

Test Plan:
- Live 13:45:30, mode_i, then 3x inc_i, mode_i, mode_i, mode_i -> load_o one cycle with hour 16, min 45, sec 30; editing_o 0 afterwards.
- Live 23:59:59, mode_i, inc_i; mode_i, inc_i; mode_i, inc_i; mode_i -> load_o with 00:00:00.
- Live 00:00:00, mode_i, dec_i -> hour_set_o 23; mode_i, dec_i -> min_set_o 59.
- In SET_MIN, 10000 tick_ms_i pulses with no buttons -> RUN, no load_o; 9999 ticks then inc_i -> still SET_MIN, counter restarted.
- In SET_SEC, mode_i and cancel_i on the same cycle -> RUN, no load_o; inc_i with dec_i together -> value unchanged.
- reset_i asserted asynchronously mid-SET_HOUR -> all outputs 0 before the next clk_i edge; state RUN.
